// File: rtl/serial_add_ctrl.sv
// Byte-serial wide-operand adder: LSB-first byte pairs in, one registered sum byte out per accept.
// Define SERIAL_ADD_SUB_EN to add the in_sub port and per-transaction subtraction.
module serial_add_ctrl #(
  parameter int MAX_BYTES = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_s,
  output logic [CNT_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_co,
  output logic             out_ovf,
  output logic             out_err
);

  typedef enum logic {ST_FIRST, ST_MID} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_BYTES - 1);
  localparam logic [CNT_W-1:0] IDX_ONE  = CNT_W'(1);

  state_t           r_state;
  logic             r_carry;
  logic [CNT_W-1:0] r_idx;

  logic             w_accept;
  logic             w_in_sub;
  logic             w_sub_q;
  logic             w_sub;
  logic [7:0]       w_b;
  logic             w_cin;
  logic [8:0]       w_sum;
  logic             w_trunc;
  logic             w_end;
  logic             w_ovf;

`ifdef SERIAL_ADD_SUB_EN
  logic r_sub;
  assign w_in_sub = in_sub;
  assign w_sub_q  = r_sub;
`else
  assign w_in_sub = 1'b0;
  assign w_sub_q  = 1'b0;
`endif

  // Only combinational path to an output: out_ready -> in_ready.
  assign in_ready = !out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  assign w_sub   = (r_state == ST_FIRST) ? w_in_sub : w_sub_q;
  assign w_b     = w_sub ? ~in_b : in_b;
  assign w_cin   = (r_state == ST_FIRST) ? w_sub : r_carry;
  assign w_sum   = {1'b0, in_a} + {1'b0, w_b} + {8'b0, w_cin};
  assign w_trunc = (r_idx == LAST_IDX) && !in_last;
  assign w_end   = in_last || w_trunc;
  assign w_ovf   = w_end && (in_a[7] == w_b[7]) && (w_sum[7] != in_a[7]);

`ifdef SERIAL_ADD_SUB_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub <= 1'b0;
    end else if (w_accept && (r_state == ST_FIRST) && !w_end) begin
      r_sub <= in_sub;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_FIRST;
      r_carry   <= 1'b0;
      r_idx     <= '0;
      out_valid <= 1'b0;
      out_s     <= 8'h00;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_co    <= 1'b0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
    end else if (w_accept) begin
      out_valid <= 1'b1;
      out_s     <= w_sum[7:0];
      out_co    <= w_sum[8];
      out_idx   <= r_idx;
      out_last  <= w_end;
      out_ovf   <= w_ovf;
      out_err   <= w_trunc;
      if (w_end) begin
        r_state <= ST_FIRST;
        r_carry <= 1'b0;
        r_idx   <= '0;
      end else begin
        r_state <= ST_MID;
        r_carry <= w_sum[8];
        r_idx   <= r_idx + IDX_ONE;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed table-driven bench for serial_add_ctrl plus hand sequences for
// back-pressure, asynchronous reset and (when enabled) subtraction.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_last;
  logic       in_sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_s;
  logic [3:0] out_idx;
  logic       out_last;
  logic       out_co;
  logic       out_ovf;
  logic       out_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.MAX_BYTES(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
`ifdef SERIAL_ADD_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_co    (out_co),
    .out_ovf   (out_ovf),
    .out_err   (out_err)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       last;
    logic [7:0] s;
    logic       co;
    logic [3:0] idx;
    logic       lst;
    logic       ovf;
    logic       err;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic [7:0] a, logic [7:0] b, logic last, logic [7:0] s,
                              logic co, logic [3:0] idx, logic lst, logic ovf, logic err);
    vec_t v;
    v.a = a; v.b = b; v.last = last; v.s = s; v.co = co;
    v.idx = idx; v.lst = lst; v.ovf = ovf; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] s, input logic co, input logic [3:0] idx,
                         input logic lst, input logic ovf, input logic err);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".s"},     32'(out_s),     32'(s));
    chk({tag, ".co"},    32'(out_co),    32'(co));
    chk({tag, ".idx"},   32'(out_idx),   32'(idx));
    chk({tag, ".last"},  32'(out_last),  32'(lst));
    chk({tag, ".ovf"},   32'(out_ovf),   32'(ovf));
    chk({tag, ".err"},   32'(out_err),   32'(err));
  endtask

  // Present one byte pair at the falling edge; it is accepted on the next rising edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last, input logic sub);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last; in_sub = sub;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; in_sub = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00;
    in_last = 1'b0; in_sub = 1'b0; out_ready = 1'b1;

    // 0x12345678 + 0x0000FFFF
    vt.push_back(mk(8'h78, 8'hFF, 1'b0, 8'h77, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(8'h56, 8'hFF, 1'b0, 8'h56, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(8'h34, 8'h00, 1'b0, 8'h35, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(8'h12, 8'h00, 1'b1, 8'h12, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0));
    // single-byte signed overflow cases
    vt.push_back(mk(8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0));
    vt.push_back(mk(8'h80, 8'h80, 1'b1, 8'h00, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0));
    // 0x7FFF + 0x0001 overflows through the chained carry
    vt.push_back(mk(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0));
    // truncation: nine bytes of 0xFF + 0x01, in_last only on the ninth
    vt.push_back(mk(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0));
    for (int i = 1; i < 8; i++)
      vt.push_back(mk(8'hFF, 8'h01, 1'b0, 8'h01, 1'b1, 4'(i), (i == 7), 1'b0, (i == 7)));
    vt.push_back(mk(8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0));

    #12;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.s",     32'(out_s),     32'd0);
    chk("rst.ready", 32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      send(vt[i].a, vt[i].b, vt[i].last, 1'b0);
      chk_out($sformatf("vec%0d", i), vt[i].s, vt[i].co, vt[i].idx, vt[i].lst, vt[i].ovf, vt[i].err);
    end
    idle();
    @(posedge clk); #1;
    chk("drain.valid", 32'(out_valid), 32'd0);
    chk("drain.hold_s", 32'(out_s), 32'h00);

    // back-pressure: output stalls, in_ready low, then simultaneous drain + accept
    send(8'h11, 8'h22, 1'b0, 1'b0);
    chk_out("bp0", 8'h33, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    out_ready = 1'b0; in_a = 8'h01; in_b = 8'h02; in_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      chk("bp.valid",    32'(out_valid), 32'd1);
      chk("bp.s",        32'(out_s),    32'h33);
      chk("bp.idx",      32'(out_idx),  32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk_out("bp1", 8'h03, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
    idle();
    @(posedge clk); #1;

    // asynchronous reset in the middle of a 4-byte add
    send(8'h78, 8'hFF, 1'b0, 1'b0);
    send(8'h56, 8'hFF, 1'b0, 1'b0);
    chk_out("pre_rst", 8'h56, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", 32'(out_valid), 32'd0);
    chk("arst.s",     32'(out_s),     32'd0);
    chk("arst.idx",   32'(out_idx),   32'd0);
    chk("arst.co",    32'(out_co),    32'd0);
    chk("arst.last",  32'(out_last),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h01, 8'h01, 1'b1, 1'b0);
    chk_out("post_rst", 8'h02, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    idle();

`ifdef SERIAL_ADD_SUB_EN
    // 0x0100 - 0x0001; in_sub ignored on the second byte
    send(8'h00, 8'h01, 1'b0, 1'b1);
    chk_out("sub0", 8'hFF, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    send(8'h01, 8'h00, 1'b1, 1'b0);
    chk_out("sub1", 8'h00, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
    idle();
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Byte-serial wide-operand adder stage built around our 8-bit ripple-carry datapath. It accepts operand byte pairs LSB-first over a valid/ready stream and adds each pair with a registered carry chained between bytes. It emits one registered sum byte per accepted input byte, and reports the final carry-out and signed overflow on the last byte. It sits between the operand source (register file or DMA byte stream) and the result sink, so operands of arbitrary length reuse a single 8-bit adder.

## Interface
- `MAX_BYTES`, default 8: maximum bytes per transaction (2..2^CNT_W).
- `CNT_W`, default 4: width of the byte-index counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand byte pair valid.
- `in_ready` out 1: stage can accept a byte pair this cycle.
- `in_a` in 8: operand A byte.
- `in_b` in 8: operand B byte.
- `in_last` in 1: this byte pair is the MSB byte of the transaction.
- `in_sub` in 1: subtract (A−B); sampled on the first byte only. Present only with `SERIAL_ADD_SUB_EN`.
- `out_valid` out 1: result byte valid.
- `out_ready` in 1: sink accepts the result byte.
- `out_s` out 8: sum byte.
- `out_idx` out CNT_W: byte index of `out_s`; 0 is the LSB.
- `out_last` out 1: final byte of the transaction.
- `out_co` out 1: carry-out of this byte; meaningful as the final carry when `out_last` is 1.
- `out_ovf` out 1: signed overflow; valid only with `out_last`, 0 otherwise.
- `out_err` out 1: transaction truncated at MAX_BYTES; asserted only with `out_last`.

## Operation
- States:
  - FIRST: the next accepted byte starts a transaction. Carry-in is 0 (add) or 1 (sub).
  - MID: carry-in is `carry_q`.
- Accept condition: `in_valid && in_ready`, where `in_ready = !out_valid || out_ready`. This gives a single output register with pass-through back-pressure.
- On accept:
  - Compute `{co,s} = a + b' + cin`, with `b' = sub ? ~in_b : in_b`.
  - Load `out_s`, `out_co`, `out_idx = idx_q`, `out_last`, `out_ovf`, `out_err`, and set `out_valid = 1`.
  - Set `carry_q = co`.
- `out_ovf = (a[7] == b'[7]) && (s[7] != a[7])`, computed on the last byte only.
- Transitions:
  - FIRST → MID on an accepted byte with `in_last = 0`. Latch `sub_q = in_sub` and set `idx_q = 1`.
  - MID → MID on an accepted non-last byte. Increment `idx_q`.
  - Any state → FIRST on an accepted byte with `in_last = 1`. Clear `carry_q` and `idx_q`.
- Truncation: if an accepted byte has `idx_q == MAX_BYTES-1` and `in_last = 0`:
  - Treat it as last: `out_last = 1`, `out_err = 1`, return to FIRST.
  - The following byte starts a fresh transaction.
- `in_sub` is ignored in MID. The operation is fixed per transaction.
- When `out_valid && out_ready` with no new accept, clear `out_valid`. Data outputs hold their last values.
- Reset (async, any time, including mid-transaction):
  - `out_valid = 0`; `out_s`, `out_idx`, `out_co`, `out_last`, `out_ovf`, `out_err` = 0.
  - `carry_q = 0`, `idx_q = 0`, `sub_q = 0`, state FIRST.
  - The partial transaction is discarded.

## Timing
- Latency: 1 cycle from input accept to `out_valid`.
- Throughput: 1 byte/cycle with `out_ready` held high.
- Outputs are stable while `out_valid && !out_ready`. `in_ready` is low in that condition.
- Simultaneous drain and accept in one cycle: the new byte replaces the old one and `out_valid` stays 1.
- The combinational path is `out_ready` → `in_ready` only. There is no path from `in_*` to `out_*`.
- Single-byte transaction (`in_last` on the first byte): FIRST carry-in rules apply and the state stays FIRST.

## Configuration
- `SERIAL_ADD_SUB_EN` defined:
  - The `in_sub` port exists.
  - Subtraction uses inverted B and carry-in 1 on the first byte.
  - `out_co = 1` on the last byte means no borrow.
- Not defined:
  - No `in_sub` port; internal `sub_q` is tied to 0.
  - The block is add-only; first-byte carry-in is always 0.

## Test plan
- Add 0x12345678 + 0x0000FFFF as 4 bytes, LSB-first, `out_ready = 1`:
  - Bytes out 0x77, 0x56, 0x35, 0x12 at idx 0..3.
  - `out_co` per byte 1, 1, 0, 0.
  - `out_last` on idx 3; `out_ovf = 0`.
- Single byte 0x7F + 0x01 with `in_last = 1` → `out_s = 0x80`, `out_co = 0`, `out_ovf = 1`, `out_last = 1`.
- With `SERIAL_ADD_SUB_EN`: 0x0100 − 0x0001 (`in_sub = 1` on byte 0, `in_sub = 0` on byte 1) → bytes 0xFF then 0x00; final `out_co = 1`, `out_ovf = 0`.
- Back-pressure: hold `out_ready = 0` for 3 cycles with `in_valid = 1`:
  - `in_ready = 0` throughout; `out_s`/`out_idx` stable.
  - On release, the next byte is accepted the same cycle and `out_valid` stays high.
- Truncation, MAX_BYTES = 8: 9 bytes of 0xFF + 0x01 with no `in_last` until byte 9:
  - Byte idx 7 reports `out_last = 1`, `out_err = 1`.
  - Byte 9 reports `out_s = 0x00`, `out_co = 1`, idx 0 (fresh carry 0), `out_last = 1`, `out_err = 0`.
- Assert `rst_n = 0` after 2 bytes of a 4-byte add:
  - All outputs go to 0 immediately.
  - After release, a new 0x01 + 0x01 single-byte add yields 0x02 with `out_co = 0`, confirming the carry was cleared.
